// File: rtl/stack_eval_engine.sv
// Stack-machine evaluator: executes opcode/literal words against an on-chip operand stack.
// Latency: single-cycle ops update the stack one cycle after acceptance; DIV takes DATA_W cycles.
// Backpressure: in_ready drops while a result waits for res_ready or a divide runs.
// Optional restoring divider for opcode 11 is enabled by defining STACK_EVAL_DIV_EN.
module stack_eval_engine #(
    parameter int DATA_W      = 32,
    parameter int STACK_DEPTH = 16,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_op,
    input  logic [DATA_W-1:0]  in_operand,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [DATA_W-1:0]  res_data,
    output logic               err_valid,
    output logic [2:0]         err_code,
    output logic [DEPTH_W-1:0] depth,
    output logic               busy
);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_PUSH  = 4'd1;
    localparam logic [3:0] OP_POP   = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MUL   = 4'd5;
    localparam logic [3:0] OP_NEG   = 4'd6;
    localparam logic [3:0] OP_DUP   = 4'd7;
    localparam logic [3:0] OP_SWAP  = 4'd8;
    localparam logic [3:0] OP_EMIT  = 4'd9;
    localparam logic [3:0] OP_CLEAR = 4'd10;
    localparam logic [3:0] OP_DIV   = 4'd11;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_UNDERFLOW = 3'd1;
    localparam logic [2:0] ERR_OVERFLOW  = 3'd2;
    localparam logic [2:0] ERR_ILLEGAL   = 3'd3;
    localparam logic [2:0] ERR_DIVZERO   = 3'd4;

    typedef enum logic [1:0] {
        ST_READY,
        ST_EMIT_HOLD,
        ST_DIV_RUN
    } state_t;

    state_t state, state_next;

    // Entry 0 is top of stack; pushes shift entries toward higher indices.
    logic [DATA_W-1:0] stk [STACK_DEPTH];
    logic [DATA_W-1:0] tos, nos;
    logic [DATA_W-1:0] bin_res;
    logic              alive;
    logic              accept;
    logic              exec;
    logic              is_empty, lt_two, is_full;
    logic [2:0]        err_det;
    logic              div_done;
    logic [DATA_W-1:0] div_quot;

    assign tos      = stk[0];
    assign nos      = stk[1];
    assign is_empty = (depth == '0);
    assign lt_two   = (depth < DEPTH_W'(2));
    assign is_full  = (depth == DEPTH_W'(STACK_DEPTH));

    // alive holds in_ready low while reset is asserted and until the first clock after release.
    assign in_ready = alive && (state == ST_READY);
    assign accept   = in_valid && in_ready;
    assign exec     = accept && (err_det == ERR_NONE);

    // Operand-count and opcode legality check for the word being offered.
    always_comb begin
        err_det = ERR_NONE;
        case (in_op)
            OP_NOP, OP_CLEAR: err_det = ERR_NONE;
            OP_PUSH: if (is_full) err_det = ERR_OVERFLOW;
            OP_POP, OP_NEG, OP_EMIT: if (is_empty) err_det = ERR_UNDERFLOW;
            OP_DUP: begin
                if (is_empty)     err_det = ERR_UNDERFLOW;
                else if (is_full) err_det = ERR_OVERFLOW;
            end
            OP_ADD, OP_SUB, OP_MUL, OP_SWAP: if (lt_two) err_det = ERR_UNDERFLOW;
            OP_DIV: begin
`ifdef STACK_EVAL_DIV_EN
                if (lt_two)           err_det = ERR_UNDERFLOW;
                else if (tos == '0)   err_det = ERR_DIVZERO;
`else
                err_det = ERR_ILLEGAL;
`endif
            end
            default: err_det = ERR_ILLEGAL;
        endcase
    end

    // Binary ALU result (NOS op TOS), all modulo 2^DATA_W.
    always_comb begin
        bin_res = '0;
        case (in_op)
            OP_ADD:  bin_res = nos + tos;
            OP_SUB:  bin_res = nos - tos;
            OP_MUL:  bin_res = nos * tos;
            default: bin_res = '0;
        endcase
    end

`ifdef STACK_EVAL_DIV_EN
    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] div_q, div_r, div_d;
    logic [CNT_W-1:0]  div_cnt;
    logic [DATA_W:0]   r_sh, r_sub;
    logic              q_bit;
    logic [DATA_W-1:0] r_new, q_new;

    // One restoring-division step: shift in next dividend bit, subtract if it fits.
    always_comb begin
        r_sh     = {div_r, div_q[DATA_W-1]};
        r_sub    = r_sh - {1'b0, div_d};
        q_bit    = ~r_sub[DATA_W];
        r_new    = q_bit ? r_sub[DATA_W-1:0] : r_sh[DATA_W-1:0];
        q_new    = {div_q[DATA_W-2:0], q_bit};
        div_done = (state == ST_DIV_RUN) && (div_cnt == CNT_W'(DATA_W - 1));
        div_quot = q_new;
    end

    // Divider working registers: load on DIV acceptance, iterate while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            div_r   <= '0;
            div_d   <= '0;
            div_cnt <= '0;
        end else if (exec && in_op == OP_DIV) begin
            div_q   <= nos;
            div_r   <= '0;
            div_d   <= tos;
            div_cnt <= '0;
        end else if (state == ST_DIV_RUN) begin
            div_q   <= q_new;
            div_r   <= r_new;
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    assign busy = (state == ST_DIV_RUN);
`else
    assign div_done = 1'b0;
    assign div_quot = '0;
    assign busy     = 1'b0;
`endif

    // Stack storage; occupancy is tracked separately so data needs no reset.
    always_ff @(posedge clk) begin
        if (exec) begin
            case (in_op)
                OP_PUSH, OP_DUP: begin
                    stk[0] <= (in_op == OP_PUSH) ? in_operand : tos;
                    for (int i = 1; i < STACK_DEPTH; i++) stk[i] <= stk[i-1];
                end
                OP_POP, OP_EMIT: begin
                    for (int i = 0; i < STACK_DEPTH - 1; i++) stk[i] <= stk[i+1];
                end
                OP_ADD, OP_SUB, OP_MUL: begin
                    stk[0] <= bin_res;
                    for (int i = 1; i < STACK_DEPTH - 1; i++) stk[i] <= stk[i+1];
                end
                OP_NEG: stk[0] <= -tos;
                OP_SWAP: begin
                    stk[0] <= nos;
                    stk[1] <= tos;
                end
                default: ;
            endcase
        end else if (div_done) begin
            stk[0] <= div_quot;
            for (int i = 1; i < STACK_DEPTH - 1; i++) stk[i] <= stk[i+1];
        end
    end

    // Occupancy count and the post-reset enable flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= '0;
            alive <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (exec) begin
                case (in_op)
                    OP_PUSH, OP_DUP: depth <= depth + DEPTH_W'(1);
                    OP_POP, OP_EMIT, OP_ADD, OP_SUB, OP_MUL: depth <= depth - DEPTH_W'(1);
                    OP_CLEAR: depth <= '0;
                    default: ;
                endcase
            end else if (div_done) begin
                depth <= depth - DEPTH_W'(1);
            end
        end
    end

    // Error pulse, result register and FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            res_valid <= 1'b0;
            res_data  <= '0;
            state     <= ST_READY;
        end else begin
            err_valid <= accept && (err_det != ERR_NONE);
            err_code  <= accept ? err_det : ERR_NONE;
            state     <= state_next;
            if (exec && in_op == OP_EMIT) begin
                res_valid <= 1'b1;
                res_data  <= tos;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    // Next-state: EMIT waits for the result handshake, DIV runs the divider.
    always_comb begin
        state_next = state;
        case (state)
            ST_READY: begin
                if (exec && in_op == OP_EMIT) state_next = ST_EMIT_HOLD;
`ifdef STACK_EVAL_DIV_EN
                else if (exec && in_op == OP_DIV) state_next = ST_DIV_RUN;
`endif
            end
            ST_EMIT_HOLD: if (res_valid && res_ready) state_next = ST_READY;
`ifdef STACK_EVAL_DIV_EN
            ST_DIV_RUN: if (div_done) state_next = ST_READY;
`endif
            default: state_next = ST_READY;
        endcase
    end

endmodule

// File: doc/stack_eval_engine.md
# stack_eval_engine

Parametrised hardware stack-machine evaluator: consumes a stream of code words (opcode plus literal) over a valid/ready handshake and executes them against an on-chip operand stack. Generalised successor of the software interpreter/evaluator flow, with configurable data width and stack depth, checked arithmetic errors, a back-pressured result port and an optional multicycle divider. Sits downstream of a code generator or instruction FIFO and upstream of a result consumer.

## Interface
- DATA_W, 32, operand/result width in bits (≥2)
- STACK_DEPTH, 16, operand stack entries (≥2)
- DEPTH_W, $clog2(STACK_DEPTH+1), width of depth count (derived; do not override)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  code word valid
- in_ready  out  1  engine accepts code word this cycle
- in_op  in  4  opcode
- in_operand  in  DATA_W  literal (used by PUSH only)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  DATA_W  result value
- err_valid  out  1  one-cycle error pulse
- err_code  out  3  1 underflow, 2 overflow, 3 illegal op, 4 divide by zero
- depth  out  DEPTH_W  current stack occupancy
- busy  out  1  divide in progress

## Operation
- Opcodes (TOS = top, NOS = next; binary result = NOS op TOS, depth −1): 0 NOP, 1 PUSH literal, 2 POP, 3 ADD, 4 SUB, 5 MUL (low DATA_W bits), 6 NEG (two's complement of TOS), 7 DUP, 8 SWAP, 9 EMIT (pop TOS to result port), 10 CLEAR (depth←0), 11 DIV (unsigned NOS/TOS, see Configuration), 12–15 illegal.
- All arithmetic modulo 2^DATA_W, no saturation, no flags.
- Operand requirements: POP/NEG/DUP/EMIT need depth≥1; binary ops/SWAP need ≥2; else underflow. PUSH/DUP at depth==STACK_DEPTH → overflow.
- Any error: op discarded, stack and depth unchanged, err_valid pulsed with code; engine continues.
- FSM: READY → (EMIT accepted) EMIT_HOLD → (res_valid&&res_ready) READY; READY → (DIV accepted, no error) DIV_RUN → (after DATA_W iterations) READY. Other ops stay in READY.
- CLEAR at depth 0 is legal, no error. NOP never errors.

## Timing
- Reset values: in_ready 0 during reset, 1 the first cycle after release; res_valid 0; res_data 0; err_valid 0; err_code 0; depth 0; busy 0; FSM READY.
- in_ready = (state==READY). Accept = in_valid && in_ready.
- Single-cycle ops: accepted at T, stack and depth updated at T+1; one op per cycle back-to-back.
- err_valid/err_code asserted at T+1 for exactly one cycle; err_code 0 when err_valid low.
- EMIT at T: res_valid and res_data valid from T+1, held stable until res_ready; in_ready low while res_valid high; in_ready returns the cycle after the result handshake.
- DIV at T: busy high T+1..T+DATA_W, quotient pushed with busy falling; in_ready low throughout.
- Asynchronous reset mid-DIV or mid-EMIT_HOLD: operation aborted, pending result dropped, all outputs to reset values.
- in_op/in_operand ignored when not accepted.

## Configuration
- STACK_EVAL_DIV_EN defined: opcode 11 implemented as restoring unsigned divider, DATA_W cycles; TOS==0 → divide-by-zero error (code 4), no DIV_RUN entry, stack unchanged.
- Undefined: no divider logic; opcode 11 → illegal op (code 3); busy tied 0.

## Test plan
- Reset release, PUSH 7, PUSH 5, SUB, EMIT, res_ready=1 → res_data=2, depth 0, no err.
- DATA_W=32: PUSH 0xFFFFFFFF, PUSH 2, MUL, EMIT → res_data=0xFFFFFFFE (wrap).
- Empty stack ADD → err_valid 1 cycle, err_code=1, depth 0; STACK_DEPTH+1 PUSHes → last gives err_code=2, depth=STACK_DEPTH.
- EMIT with res_ready=0 for 5 cycles → res_valid/res_data stable, in_ready 0; res_ready=1 → handshake, in_ready 1 next cycle.
- With STACK_EVAL_DIV_EN: PUSH 100, PUSH 7, DIV, EMIT → busy high DATA_W cycles, res_data=14; PUSH 1, PUSH 0, DIV → err_code=4, depth 2. Without macro: DIV → err_code=3.
- Assert rst_n low mid-DIV → busy 0, depth 0, res_valid 0 immediately; PUSH 3, EMIT after release → res_data=3.
